// File: rtl/i2c_ctrl_queue.sv
// Descriptor queue feeding the I2C master FSM: DEPTH-entry circular buffer plus one active register set.
// Optional push validation (clock divider and 7-bit address range) is enabled by defining I2C_CTRL_VALIDATE_EN.
package i2c_pkg;
    typedef enum logic {TX = 1'b0, RX = 1'b1} DataDirection;
    typedef enum logic {ADDR_7_BIT = 1'b0, ADDR_10_BIT = 1'b1} AddressMode;
endpackage

module i2c_ctrl_queue
    import i2c_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int DIV_W     = 32,
    parameter int RESET_DIV = 300
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [9:0]                 u_bus_address,
    input  DataDirection               u_data_direction,
    input  AddressMode                 u_address_mode,
    input  logic                       u_stretch_enabled,
    input  logic [DIV_W-1:0]           u_clock_div,
    input  logic                       push,
    output logic                       push_ready,
    input  logic                       load_buffer,
    input  logic                       flush,
    output logic [9:0]                 bus_address,
    output DataDirection               data_direction,
    output AddressMode                 address_mode,
    output logic                       stretch_enabled,
    output logic [DIV_W-1:0]           clock_div,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
`ifdef I2C_CTRL_VALIDATE_EN
    output logic                       cfg_error,
`endif
    output logic                       load_miss
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [9:0]       addr;
        DataDirection     dir;
        AddressMode       mode;
        logic             stretch;
        logic [DIV_W-1:0] div;
    } desc_t;

    localparam desc_t RESET_DESC = '{addr: 10'd0, dir: RX, mode: ADDR_7_BIT,
                                     stretch: 1'b1, div: DIV_W'(RESET_DIV)};

    desc_t          mem_q [DEPTH];
    desc_t          active_q, active_d, in_desc;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           overflow_q, overflow_d;
    logic           load_miss_q, load_miss_d;
    logic           wr_en, do_load, push_valid;

    assign in_desc = '{addr: u_bus_address, dir: u_data_direction, mode: u_address_mode,
                       stretch: u_stretch_enabled, div: u_clock_div};

    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign push_ready = !full;

`ifdef I2C_CTRL_VALIDATE_EN
    logic cfg_error_q, cfg_error_d;
    assign cfg_error  = cfg_error_q;
    assign push_valid = !((u_clock_div < DIV_W'(4)) ||
                          (u_address_mode == ADDR_7_BIT && u_bus_address[9:7] != 3'b000));
`else
    assign push_valid = 1'b1;
`endif

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        load_miss_d = 1'b0;
        active_d    = active_q;
        wr_en       = 1'b0;
        do_load     = 1'b0;
`ifdef I2C_CTRL_VALIDATE_EN
        cfg_error_d = 1'b0;
`endif
        if (flush) begin
            // Flush wins over everything in the same cycle; active descriptor survives.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                if (full) begin
                    overflow_d = 1'b1;
                end else if (push_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end
`ifdef I2C_CTRL_VALIDATE_EN
                else begin
                    cfg_error_d = 1'b1;
                end
`endif
            end
            if (load_buffer) begin
                if (empty) begin
                    load_miss_d = 1'b1;
                end else begin
                    do_load  = 1'b1;
                    active_d = mem_q[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
            end
            count_d = count_q + CW'(wr_en) - CW'(do_load);
        end
    end

    // Queue storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_desc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            load_miss_q <= 1'b0;
            active_q    <= RESET_DESC;
`ifdef I2C_CTRL_VALIDATE_EN
            cfg_error_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            load_miss_q <= load_miss_d;
            active_q    <= active_d;
`ifdef I2C_CTRL_VALIDATE_EN
            cfg_error_q <= cfg_error_d;
`endif
        end
    end

    assign bus_address     = active_q.addr;
    assign data_direction  = active_q.dir;
    assign address_mode    = active_q.mode;
    assign stretch_enabled = active_q.stretch;
    assign clock_div       = active_q.div;
    assign count           = count_q;
    assign overflow        = overflow_q;
    assign load_miss       = load_miss_q;
endmodule

// File: tb/tb_i2c_ctrl_queue.sv
// Bench for i2c_ctrl_queue: queue-based reference model checked every cycle, plus literal spot checks.
module tb_i2c_ctrl_queue;
    import i2c_pkg::*;
    localparam int DEPTH = 4;
    localparam int DIV_W = 32;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk, rst;
    logic [9:0]       u_bus_address;
    DataDirection     u_data_direction;
    AddressMode       u_address_mode;
    logic             u_stretch_enabled;
    logic [DIV_W-1:0] u_clock_div;
    logic             push, push_ready, load_buffer, flush;
    logic [9:0]       bus_address;
    DataDirection     data_direction;
    AddressMode       address_mode;
    logic             stretch_enabled;
    logic [DIV_W-1:0] clock_div;
    logic [CW-1:0]    count;
    logic             empty, full, overflow, load_miss;
`ifdef I2C_CTRL_VALIDATE_EN
    logic             cfg_error;
`endif

    i2c_ctrl_queue #(.DEPTH(DEPTH), .DIV_W(DIV_W), .RESET_DIV(300)) dut (
        .clk(clk), .rst(rst),
        .u_bus_address(u_bus_address), .u_data_direction(u_data_direction),
        .u_address_mode(u_address_mode), .u_stretch_enabled(u_stretch_enabled),
        .u_clock_div(u_clock_div), .push(push), .push_ready(push_ready),
        .load_buffer(load_buffer), .flush(flush), .bus_address(bus_address),
        .data_direction(data_direction), .address_mode(address_mode),
        .stretch_enabled(stretch_enabled), .clock_div(clock_div), .count(count),
        .empty(empty), .full(full), .overflow(overflow),
`ifdef I2C_CTRL_VALIDATE_EN
        .cfg_error(cfg_error),
`endif
        .load_miss(load_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  addr;
        logic        dir;
        logic        mode;
        logic        st;
        logic [31:0] div;
    } d_t;

    d_t  mq[$];
    d_t  m_act, cur;
    bit  m_ovf, m_miss, m_cerr;
    int  m_sz;
    bit  chk_en;
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit cfg_ok(input d_t d);
`ifdef I2C_CTRL_VALIDATE_EN
        return !(d.div < 4 || (d.mode == 1'b0 && d.addr[9:7] != 3'b000));
`else
        return 1'b1;
`endif
    endfunction

    // Reference model: a plain FIFO of descriptors plus the active descriptor.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_act  = '{10'd0, 1'b1, 1'b0, 1'b1, 32'd300};
            m_ovf  = 0;
            m_miss = 0;
            m_cerr = 0;
        end else if (flush) begin
            mq.delete();
            m_ovf  = 0;
            m_miss = 0;
            m_cerr = 0;
        end else begin
            cur    = '{u_bus_address, u_data_direction, u_address_mode, u_stretch_enabled, u_clock_div};
            m_sz   = mq.size();
            m_miss = load_buffer && (m_sz == 0);
            m_cerr = 0;
            if (load_buffer && m_sz > 0) m_act = mq.pop_front();
            if (push) begin
                if (m_sz == DEPTH) m_ovf = 1;
                else if (cfg_ok(cur)) mq.push_back(cur);
                else m_cerr = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("bus_address", bus_address, m_act.addr);
            chk("data_direction", data_direction, m_act.dir);
            chk("address_mode", address_mode, m_act.mode);
            chk("stretch_enabled", stretch_enabled, m_act.st);
            chk("clock_div", clock_div, m_act.div);
            chk("count", count, mq.size());
            chk("empty", empty, mq.size() == 0);
            chk("full", full, mq.size() == DEPTH);
            chk("push_ready", push_ready, mq.size() != DEPTH);
            chk("overflow", overflow, m_ovf);
            chk("load_miss", load_miss, m_miss);
`ifdef I2C_CTRL_VALIDATE_EN
            chk("cfg_error", cfg_error, m_cerr);
`endif
        end
    end

    task automatic drive(input bit p, input bit l, input bit f, input logic [9:0] a,
                         input logic [31:0] dv, input AddressMode m, input DataDirection d, input bit st);
        push = p; load_buffer = l; flush = f;
        u_bus_address = a; u_clock_div = dv; u_address_mode = m;
        u_data_direction = d; u_stretch_enabled = st;
        @(posedge clk);
        #2;
        push = 0; load_buffer = 0; flush = 0;
    endtask

    task automatic do_push(input logic [9:0] a, input logic [31:0] dv);
        drive(1, 0, 0, a, dv, ADDR_10_BIT, TX, 1'b0);
    endtask

    task automatic do_load();
        drive(0, 1, 0, 10'h000, 32'd100, ADDR_10_BIT, TX, 1'b0);
    endtask

    task automatic idle();
        drive(0, 0, 0, 10'h000, 32'd100, ADDR_10_BIT, TX, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_addr"}, bus_address, 10'h000);
        chk({tag, "_dir"}, data_direction, RX);
        chk({tag, "_mode"}, address_mode, ADDR_7_BIT);
        chk({tag, "_stretch"}, stretch_enabled, 1'b1);
        chk({tag, "_div"}, clock_div, 32'd300);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_empty"}, empty, 1'b1);
        chk({tag, "_full"}, full, 1'b0);
        chk({tag, "_ready"}, push_ready, 1'b1);
        chk({tag, "_ovf"}, overflow, 1'b0);
        chk({tag, "_miss"}, load_miss, 1'b0);
    endtask

    initial begin
        rst = 0; chk_en = 0;
        push = 0; load_buffer = 0; flush = 0;
        u_bus_address = '0; u_clock_div = 32'd100; u_address_mode = ADDR_10_BIT;
        u_data_direction = TX; u_stretch_enabled = 0;

        // Asynchronous reset between clock edges.
        #13 rst = 1;
        #1 check_reset_vals("rst");
        repeat (2) @(posedge clk);
        #2 rst = 0;
        chk_en = 1;
        idle();

        // FIFO order with pointer wrap.
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, 10'h010 + 10'(i), 32'd100 + 32'(i),
                  i[0] ? ADDR_10_BIT : ADDR_7_BIT, i[0] ? RX : TX, i[1]);
            chk("fifo_addr_before_load", bus_address, (i == 0) ? 10'h000 : 10'h010 + 10'(i - 1));
            do_load();
            chk("fifo_addr", bus_address, 10'h010 + 10'(i));
            chk("fifo_div", clock_div, 32'd100 + 32'(i));
        end
        chk("fifo_last_addr", bus_address, 10'h015);
        chk("fifo_last_div", clock_div, 32'd105);

        // Full, overflow, and push+load while full.
        for (int i = 0; i < 4; i++) do_push(10'h020 + 10'(i), 32'd200 + 32'(i));
        chk("full_flag", full, 1'b1);
        chk("full_ready", push_ready, 1'b0);
        do_push(10'h3FF, 32'd999);
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_count", count, 4);
        drive(1, 1, 0, 10'h1AB, 32'd50, ADDR_10_BIT, TX, 1'b0);
        chk("full_pl_count", count, 3);
        chk("full_pl_addr", bus_address, 10'h020);
        for (int i = 0; i < 3; i++) do_load();
        chk("drain_addr", bus_address, 10'h023);
        chk("drain_div", clock_div, 32'd203);
        chk("drain_count", count, 0);

        // Loads on an empty queue.
        do_load();
        chk("miss_pulse", load_miss, 1'b1);
        chk("miss_hold_addr", bus_address, 10'h023);
        idle();
        chk("miss_clear", load_miss, 1'b0);
        drive(1, 1, 0, 10'h055, 32'd77, ADDR_10_BIT, RX, 1'b1);
        chk("empty_pl_miss", load_miss, 1'b1);
        chk("empty_pl_count", count, 1);
        do_load();
        chk("empty_pl_addr", bus_address, 10'h055);

        // Flush with concurrent push and load.
        for (int i = 0; i < 4; i++) do_push(10'h030 + 10'(i), 32'd40 + 32'(i));
        do_push(10'h034, 32'd44);
        do_load();
        chk("pre_flush_count", count, 3);
        chk("pre_flush_ovf", overflow, 1'b1);
        drive(1, 1, 1, 10'h066, 32'd66, ADDR_10_BIT, TX, 1'b0);
        chk("flush_count", count, 0);
        chk("flush_ovf", overflow, 1'b0);
        chk("flush_miss", load_miss, 1'b0);
        chk("flush_addr", bus_address, 10'h030);
        do_load();
        chk("post_flush_miss", load_miss, 1'b1);
        chk("post_flush_addr", bus_address, 10'h030);

        // Reset in the middle of operation.
        do_push(10'h0AA, 32'd10);
        do_push(10'h0BB, 32'd11);
        do_load();
        #3 rst = 1;
        #1 check_reset_vals("midrst");
        @(posedge clk);
        #2 rst = 0;
        idle();

`ifdef I2C_CTRL_VALIDATE_EN
        drive(1, 0, 0, 10'h005, 32'd3, ADDR_10_BIT, TX, 1'b0);
        chk("val_div_err", cfg_error, 1'b1);
        chk("val_div_count", count, 0);
        idle();
        chk("val_err_clear", cfg_error, 1'b0);
        drive(1, 0, 0, 10'h080, 32'd100, ADDR_7_BIT, TX, 1'b0);
        chk("val_addr7_err", cfg_error, 1'b1);
        chk("val_addr7_count", count, 0);
        drive(1, 0, 0, 10'h080, 32'd4, ADDR_10_BIT, TX, 1'b0);
        chk("val_addr10_err", cfg_error, 1'b0);
        chk("val_addr10_count", count, 1);
        do_load();
        chk("val_addr10_active", bus_address, 10'h080);
`endif

        idle();
        idle();
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/i2c_ctrl_queue.md
Name: i2c_ctrl_queue

Overview:
- Parametrised successor to the master's single-entry control holding register.
- Queues up to DEPTH I2C transaction descriptors written by the APB register front end: bus address, direction, address mode, stretch enable and clock divider.
- Drives one "active" descriptor to the master FSM. The FSM advances to the next queued descriptor at each transaction boundary, so software can post back-to-back transactions without waiting for completion.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- DIV_W, 32, clock-divider width.
- RESET_DIV, 300, active clock_div value after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- u_bus_address  in  10  descriptor slave address
- u_data_direction  in  DataDirection  descriptor direction (TX/RX, from i2c.vh)
- u_address_mode  in  AddressMode  descriptor address mode (ADDR_7_BIT/ADDR_10_BIT)
- u_stretch_enabled  in  1  descriptor clock-stretch enable
- u_clock_div  in  DIV_W  descriptor SCL divider
- push  in  1  write descriptor into queue tail
- push_ready  out  1  queue can accept; equals !full
- load_buffer  in  1  FSM request: pop queue head into active registers
- flush  in  1  discard all queued descriptors
- bus_address  out  10  active address
- data_direction  out  DataDirection  active direction
- address_mode  out  AddressMode  active address mode
- stretch_enabled  out  1  active stretch enable
- clock_div  out  DIV_W  active divider
- count  out  $clog2(DEPTH+1)  queued entries (excludes active)
- empty  out  1  count==0
- full  out  1  count==DEPTH
- overflow  out  1  sticky: push attempted while full
- load_miss  out  1  one-cycle pulse: load_buffer while empty

Behaviour:
- Reset (async, rst high), all outputs forced immediately:
  - bus_address=0, data_direction=RX, address_mode=ADDR_7_BIT, stretch_enabled=1, clock_div=RESET_DIV.
  - count=0, empty=1, full=0, push_ready=1, overflow=0, load_miss=0.
  - Pointers=0. Queue storage contents don't-care.
- Storage: circular buffer, write pointer and read pointer of $clog2(DEPTH) bits, natural wrap from DEPTH-1 to 0. count is a separate register. empty and full are decoded from count.
- Push:
  - Accepted on a clk edge with push=1 and full=0: entry written at the write pointer, write pointer increments.
  - push=1 with full=1: descriptor dropped, overflow set, no state change otherwise.
- Load:
  - load_buffer=1 and empty=0: head copied to the active registers at that edge (visible the next cycle, 1-cycle latency); read pointer increments.
  - load_buffer=1 and empty=1: active registers hold, load_miss pulses high for exactly the next cycle.
- Active registers change only on a successful load or on reset. Otherwise they hold.
- Simultaneous push and load:
  - Not empty, not full: both occur, count unchanged.
  - Empty: load misses (no bypass), push stored, count becomes 1.
  - Full: push dropped and overflow set (push_ready is not combinationally widened by load), load succeeds, count becomes DEPTH-1.
- Flush:
  - Highest priority: pointers=0, count=0, overflow cleared.
  - Any concurrent push or load in that cycle is ignored; no load_miss.
  - Active registers are retained.
- count never exceeds DEPTH and never underflows.
- Reset asserted mid-operation: queue contents lost, active registers return to reset values.

Optional Feature:
- Macro I2C_CTRL_VALIDATE_EN.
- Defined: a push is additionally rejected (not stored, count unchanged) if either holds:
  - u_clock_div < 4, or
  - u_address_mode==ADDR_7_BIT and u_bus_address[9:7]!=0.
  - A rejection pulses the extra output port cfg_error for one cycle. The port exists only when the macro is defined.
  - Rejection does not set overflow. If full, overflow takes precedence and cfg_error does not pulse.
- Undefined: no validation, no cfg_error port, every push with !full is stored.

Test Plan:
- Reset values: assert rst mid-cycle with no clk edge → outputs immediately take 0/RX/ADDR_7_BIT/1/300, count=0, empty=1.
- FIFO order and wrap: push 6 descriptors (addr 0x10..0x15, clock_div 100..105) interleaved with 6 loads, DEPTH=4 → active values appear in order 0x10..0x15, each one cycle after its load; pointers wrap.
- Full and overflow: push 4 → full=1, push_ready=0; 5th push (addr 0x3FF) → overflow=1, entry absent. A subsequent push+load in the same cycle → load succeeds, push dropped, count=3.
- Empty load: load_buffer with count=0 → load_miss high exactly 1 cycle, active unchanged. Push+load on empty → load_miss=1, count=1.
- Flush: queue 3 entries with overflow=1, assert flush together with push and load → count=0, overflow=0, active unchanged, next load → load_miss.
- Validation (macro defined): push clock_div=3 → cfg_error pulse, count unchanged. Push ADDR_7_BIT addr 0x080 → rejected. Push ADDR_10_BIT addr 0x080, clock_div=4 → accepted.
